// File: rtl/pixel_streamer_pkg.sv
// Shared types and constants for the host-side pixel streamer.
// Imported by pixel_streamer.
package pixel_streamer_pkg;

  localparam int unsigned LAYER1_WIDTH       = 784;
  localparam int unsigned PIXEL_WIDTH        = 8;
  localparam int unsigned DEFAULT_NUM_PIXELS = LAYER1_WIDTH;

  // Reported in place of a digit when the core never answers.
  localparam logic [3:0] TIMEOUT_DIGIT = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_RESULT,
    DONE
  } streamer_state_t;

  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/pixel_streamer_buffer.sv
// Simple dual-port image buffer: one synchronous write port and one
// synchronous read port with one cycle of latency. Contents are never reset.
module pixel_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 784,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pixel_streamer.sv
// Host-side driver for the core's serial pixel input: buffers one image,
// streams it on start, then latches the core's predicted digit or a timeout.
module pixel_streamer
  import pixel_streamer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = PIXEL_WIDTH,
  parameter int unsigned NUM_PIXELS     = DEFAULT_NUM_PIXELS,
  parameter int unsigned ADDR_WIDTH     = $clog2(NUM_PIXELS),
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  pause,
  output logic                  busy,
  output logic                  core_i_valid,
  output logic [DATA_WIDTH-1:0] core_pixel,
  input  logic                  core_o_valid,
  input  logic [3:0]            core_digit,
  output logic                  done,
  output logic [3:0]            result_digit,
  output logic                  timeout_err
);

  localparam int unsigned WAIT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);
  localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(TIMEOUT_CYCLES - 1);

  streamer_state_t state, state_next;

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] sent_cnt;
  logic [WAIT_WIDTH-1:0] wait_cnt;
  logic                  issued_all;
  logic                  pixel_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  logic accept_start;
  logic issue_rd;
  logic last_sent;
  logic got_result;
  logic timed_out;
  logic buf_wr;

  assign buf_wr = wr_en && !busy && addr_in_range(32'(wr_addr), NUM_PIXELS);

  pixel_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (NUM_PIXELS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (buf_wr),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (issue_rd),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next   = state;
    accept_start = 1'b0;
    issue_rd     = 1'b0;
    last_sent    = 1'b0;
    got_result   = 1'b0;
    timed_out    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          accept_start = 1'b1;
          state_next   = STREAM;
        end else begin
          state_next = IDLE;
        end
      end
      STREAM: begin
        // Stay in STREAM until the last pixel is actually on the bus, so
        // WAIT_RESULT never presents a valid pixel.
        issue_rd  = !pause && !issued_all;
        last_sent = pixel_valid && (sent_cnt == LAST_ADDR);
        if (last_sent) state_next = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (core_o_valid) begin
          got_result = 1'b1;
          state_next = DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          timed_out  = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr      <= '0;
      sent_cnt     <= '0;
      wait_cnt     <= '0;
      issued_all   <= 1'b0;
      pixel_valid  <= 1'b0;
      result_digit <= '0;
      timeout_err  <= 1'b0;
    end else begin
      pixel_valid <= issue_rd;
      if (accept_start) begin
        rd_addr     <= '0;
        sent_cnt    <= '0;
        wait_cnt    <= '0;
        issued_all  <= 1'b0;
        timeout_err <= 1'b0;
      end else begin
        if (issue_rd) begin
          rd_addr <= rd_addr + 1'b1;
          if (rd_addr == LAST_ADDR) issued_all <= 1'b1;
        end
        if (pixel_valid && state == STREAM) sent_cnt <= sent_cnt + 1'b1;
        if (state == WAIT_RESULT) wait_cnt <= wait_cnt + 1'b1;
      end
      if (got_result) begin
        result_digit <= core_digit;
      end else if (timed_out) begin
        result_digit <= TIMEOUT_DIGIT;
        timeout_err  <= 1'b1;
      end
    end
  end

  // The buffer's read register has no reset; mask it so the bus reads zero
  // whenever no pixel is being presented.
  assign core_i_valid = pixel_valid;
  assign core_pixel   = pixel_valid ? rd_data : '0;
  assign busy         = (state == STREAM) || (state == WAIT_RESULT);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_pixel_streamer.sv
// Self-checking bench for pixel_streamer: scoreboard of expected pixels plus
// a behavioural core that answers a fixed number of cycles after the last pixel.
module tb_pixel_streamer;

  localparam int NP = 784;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [9:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       core_o_valid = 1'b0;
  logic [3:0] core_digit = '0;
  logic       busy, core_i_valid, done, timeout_err;
  logic [7:0] core_pixel;
  logic [3:0] result_digit;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] mbuf [NP];
  logic [7:0] expq [$];
  int nvalid = 0;
  int last_valid_cyc = 0;
  int pix5 = -1;
  int pix300 = -1;

  int         core_lat = 0;
  logic [3:0] core_dig = '0;
  bit         stale_en = 1'b0;

  pixel_streamer #(
    .DATA_WIDTH     (8),
    .NUM_PIXELS     (NP),
    .ADDR_WIDTH     (10),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .pause        (pause),
    .busy         (busy),
    .core_i_valid (core_i_valid),
    .core_pixel   (core_pixel),
    .core_o_valid (core_o_valid),
    .core_digit   (core_digit),
    .done         (done),
    .result_digit (result_digit),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every presented pixel must be the next one of an accepted image.
  always @(negedge clk) begin : compare
    logic [7:0] e;
    if (rst && core_i_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_pixel: got pixel %0d required none", core_pixel);
      end else begin
        e = expq.pop_front();
        chk("pixel_stream", int'(core_pixel), int'(e));
      end
      if (nvalid == 5)   pix5   = int'(core_pixel);
      if (nvalid == 300) pix300 = int'(core_pixel);
      nvalid++;
      last_valid_cyc = cyc;
      chk("busy_while_valid", int'(busy), 1);
    end
  end

  // Behavioural core: answers core_lat cycles after the last pixel (0 = never).
  initial begin : core_model
    int rx;
    int cd;
    rx = 0;
    cd = 0;
    forever begin
      @(posedge clk);
      #1;
      core_o_valid = 1'b0;
      if (!rst) begin
        rx = 0;
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            core_o_valid = 1'b1;
            core_digit   = core_dig;
          end
        end
        if (core_i_valid) begin
          if (stale_en && rx == 200) begin
            core_o_valid = 1'b1;
            core_digit   = 4'd3;
          end
          rx++;
          if (rx == NP) begin
            rx = 0;
            cd = core_lat;
          end
        end
      end
    end
  end

  task automatic run(input string tag, input int lat, input logic [3:0] dig,
                     input bit pz, input bit noise, input bit stale, input bit done_wr,
                     input int exp_digit, input int exp_to, input int exp_gap);
    bit got;
    int gaps;
    core_lat = lat;
    core_dig = dig;
    stale_en = stale;
    nvalid   = 0;
    pix5     = -1;
    pix300   = -1;
    for (int i = 0; i < NP; i++) expq.push_back(mbuf[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_after_start"}, int'(busy), 1);
    chk({tag, "_no_valid_yet"}, int'(core_i_valid), 0);
    chk({tag, "_timeout_err_cleared"}, int'(timeout_err), 0);
    tick();
    chk({tag, "_first_valid"}, int'(core_i_valid), 1);
    got  = 1'b0;
    gaps = 0;
    for (int k = 0; k < 4000 && !got; k++) begin
      pause = pz && (k % 3 == 2);
      wr_en = 1'b0;
      start = 1'b0;
      if (noise && (k == 100 || k == 450)) begin
        wr_en   = 1'b1;
        wr_addr = 10'd5;
        wr_data = 8'hAA;
        start   = 1'b1;
      end
      tick();
      if (done) got = 1'b1;
      else if (!busy) gaps++;
    end
    pause = 1'b0;
    wr_en = 1'b0;
    start = 1'b0;
    chk({tag, "_done_seen"}, int'(got), 1);
    chk({tag, "_busy_gaps"}, gaps, 0);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
    chk({tag, "_valid_count"}, nvalid, NP);
    chk({tag, "_queue_drained"}, expq.size(), 0);
    chk({tag, "_result_digit"}, int'(result_digit), exp_digit);
    chk({tag, "_timeout_err"}, int'(timeout_err), exp_to);
    chk({tag, "_done_latency"}, cyc - last_valid_cyc, exp_gap);
    chk({tag, "_pixel5"}, pix5, 5);
    chk({tag, "_pixel300"}, pix300, 44);
    if (done_wr) begin
      wr_en     = 1'b1;
      wr_addr   = 10'd783;
      wr_data   = 8'hC3;
      mbuf[783] = 8'hC3;
    end
    tick();
    wr_en = 1'b0;
    chk({tag, "_done_one_cycle"}, int'(done), 0);
    chk({tag, "_result_held"}, int'(result_digit), exp_digit);
    chk({tag, "_idle_not_busy"}, int'(busy), 0);
    expq.delete();
  endtask

  initial begin
    int snap;
    repeat (3) tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(core_i_valid), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_timeout_err", int'(timeout_err), 0);
    chk("reset_result", int'(result_digit), 0);
    chk("reset_pixel", int'(core_pixel), 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < NP; i++) begin
      wr_en   = 1'b1;
      wr_addr = 10'(i);
      wr_data = 8'(i % 256);
      mbuf[i] = 8'(i % 256);
      tick();
    end
    wr_addr = 10'd800;
    wr_data = 8'h11;
    tick();
    wr_en = 1'b0;

    run("basic",    12, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 7,  0, 13);
    run("paused",   12, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 7,  0, 13);
    run("timeout",   0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 15, 1, TO + 1);
    run("busy_wr",  12, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 4,  0, 13);
    run("after_wr", 12, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1,  0, 13);

    core_lat = 12;
    stale_en = 1'b0;
    nvalid   = 0;
    for (int i = 0; i < NP; i++) expq.push_back(mbuf[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2000 && nvalid < 400; k++) tick();
    chk("rst_reached_400", nvalid, 400);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", int'(core_i_valid), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    chk("rst_mid_pixel", int'(core_pixel), 0);
    expq.delete();
    snap = nvalid;
    tick();
    tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_no_more_pixels", nvalid, snap);
    chk("rst_idle_busy", int'(busy), 0);

    run("post_rst", 12, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2,  0, 13);
    run("stale",     5, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 9,  0, 6);
    run("tie",      TO, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 5,  0, TO + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
